output_write_arbiter: RTL and testbench
=======================================

Name: output_write_arbiter

Overview:
- Packet-level arbiter that shares the 128-bit write port of the output FIFO/gearbox between two producers: src0 (PPU requant results) and src1 (softmax/layernorm results).
- Grants one source for a complete packet of N beats (one beat = one 128-bit row of 16 x INT8). Packets are never interleaved.
- Alternates round-robin between packets, tags the final beat of each packet, and stops all transfers while the downstream FIFO reports full.

Parameters:
- DATA_W, 128, beat width in bits.
- LEN_W, 9, width of packet-length inputs. Maximum length is 2^LEN_W-1 = 511 beats, which covers M=197.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s0_data  in  DATA_W  source-0 beat data.
- s0_valid  in  1  source-0 beat valid.
- s0_len  in  LEN_W  source-0 packet length in beats; sampled at grant.
- s0_ready  out  1  source-0 beat accepted when s0_valid && s0_ready.
- s0_done  out  1  one-cycle pulse after the last source-0 beat transfers.
- s1_data, s1_valid, s1_len, s1_ready, s1_done  same as source 0, for source 1.
- o_data  out  DATA_W  beat to the FIFO write port.
- o_valid  out  1  FIFO write strobe.
- o_last  out  1  high with o_valid on the final beat of a packet.
- i_full  in  1  FIFO full flag. No beat transfers while it is high.
- o_grant  out  2  one-hot current owner (01 = src0, 10 = src1, 00 = none).
- o_busy  out  1  high while in S_BURST.

Behaviour:
- Reset values: o_valid=0, o_last=0, o_grant=00, o_busy=0, s0_ready=s1_ready=0, s0_done=s1_done=0, o_data=0. FSM goes to S_IDLE, beat counter to 0, priority pointer to src0.
- Assertion of rst_n mid-packet abandons the packet immediately. No done pulse is issued, and partial beats already written stay in the FIFO.
- FSM states:
  - S_IDLE: on each cycle, examine s0_valid and s1_valid.
    - If exactly one is high, grant that source.
    - If both are high, grant the source named by the priority pointer.
    - On grant: register owner, latch len_q = sN_len (0 is treated as 1), clear beat counter, go to S_BURST.
    - No data transfers in the grant cycle, so grant costs 1 cycle of latency.
  - S_BURST:
    - The datapath is combinational: o_data = owner data, o_valid = owner_valid && !i_full, owner ready = !i_full. The non-owner's ready = 0.
    - Each cycle with o_valid=1, increment the beat counter.
    - o_last = o_valid && (cnt == len_q-1).
    - On the last transfer: pulse sN_done the next cycle, flip the priority pointer to the other source, and go to S_IDLE.
  - S_IDLE follows every packet, so there is a minimum 1-cycle bubble between packets.
- Backpressure: while i_full=1, o_valid=0 and ready=0; the counter and data are held. The owner's sN_data must stay stable (AXI-style rule). When i_full deasserts, transfer resumes in the same cycle.
- Owner deasserts valid mid-packet: stay in S_BURST and hold ownership until len_q beats have transferred; there is no timeout.
- sN_len changes during a packet: ignored. Only the grant-time value counts.
- Fairness: with both sources continuously requesting, grants alternate src0, src1, src0, and so on.
- Simultaneous events: last beat and the other source's valid in the same cycle → the next grant (after the bubble) goes to the other source.
- o_grant and o_busy are registered from FSM state. o_data, o_valid, o_last and sN_ready are combinational from registered state, sN_valid and i_full. There is no combinational path from sN_data to any control output.

Test Plan:
- Single packet: src0 only, s0_len=4, i_full=0. Expected: grant 1 cycle after valid, 4 consecutive o_valid beats, o_last on beat 4 only, s0_done pulse 1 cycle later, o_grant back to 00.
- Round-robin: both sources valid at the same time, lengths 3 and 2, data patterns 0xA..., 0xB.... Expected: src0 packet of 3 beats, then src1 packet of 2 beats, then src0 again. No interleaving, and 1 bubble between packets.
- Backpressure: src1 with s1_len=5, and i_full high for cycles 2–4 of the burst. Expected: o_valid=0 and s1_ready=0 while full, exactly 5 writes in total, no beat duplicated or lost, o_last on the 5th.
- Bubble from source: src0 with s0_len=3 and s0_valid low for 2 cycles mid-burst. Expected: src1 remains blocked until src0's 3rd beat; ownership is not lost.
- Length edges: s0_len=0 → exactly 1 beat with o_last. s0_len=197 → 197 beats, o_last only on beat 197, counter does not wrap.
- Reset mid-burst: assert rst_n=0 on beat 2 of 4. Expected: all outputs at reset values immediately, no s0_done. After release, a new packet starts cleanly with the priority pointer at src0.

Source files
------------

// File: rtl/output_write_arbiter.sv
// rtl/output_write_arbiter.sv - packet-level round-robin arbiter for the output FIFO write port
module output_write_arbiter #(
  parameter int DATA_W = 128,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_valid,
  input  logic [LEN_W-1:0]  s0_len,
  output logic              s0_ready,
  output logic              s0_done,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_valid,
  input  logic [LEN_W-1:0]  s1_len,
  output logic              s1_ready,
  output logic              s1_done,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last,
  input  logic              i_full,
  output logic [1:0]        o_grant,
  output logic              o_busy
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t           state, state_nx;
  logic             owner;      // 0 = src0, 1 = src1
  logic             prio;       // source preferred when both request
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             done0_q, done1_q;
  logic             grant_req, pick;

  assign grant_req = s0_valid || s1_valid;
  assign pick      = s1_valid && (!s0_valid || prio);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (grant_req) state_nx = S_BURST;
      S_BURST: if (o_last)    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath is a pure mux on the owner; only registered state and valid/full steer control.
  always_comb begin
    o_data   = '0;
    o_valid  = 1'b0;
    o_last   = 1'b0;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    o_grant  = 2'b00;
    o_busy   = 1'b0;
    if (state == S_BURST) begin
      o_busy   = 1'b1;
      o_grant  = owner ? 2'b10 : 2'b01;
      o_data   = owner ? s1_data : s0_data;
      o_valid  = (owner ? s1_valid : s0_valid) && !i_full;
      s0_ready = !owner && !i_full;
      s1_ready = owner && !i_full;
      o_last   = o_valid && (cnt == len_q - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= 1'b0;
      prio    <= 1'b0;
      len_q   <= '0;
      cnt     <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      if (state == S_IDLE && grant_req) begin
        owner <= pick;
        cnt   <= '0;
        if (pick) len_q <= (s1_len == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : s1_len;
        else      len_q <= (s0_len == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : s0_len;
      end else if (state == S_BURST && o_valid) begin
        cnt <= cnt + 1'b1;
        if (o_last) begin
          prio    <= !owner;
          done0_q <= !owner;
          done1_q <= owner;
        end
      end
    end
  end

  assign s0_done = done0_q;
  assign s1_done = done1_q;

endmodule

// File: tb/tb_output_write_arbiter.sv
// tb/tb_output_write_arbiter.sv - scoreboard bench for output_write_arbiter
module tb_output_write_arbiter;

  localparam int DW = 128;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s0_data, s1_data, o_data;
  logic          s0_valid, s1_valid, s0_ready, s1_ready, s0_done, s1_done;
  logic [LW-1:0] s0_len, s1_len;
  logic          o_valid, o_last, i_full, o_busy;
  logic [1:0]    o_grant;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;

  output_write_arbiter #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_len(s0_len), .s0_ready(s0_ready), .s0_done(s0_done),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_len(s1_len), .s1_ready(s1_ready), .s1_done(s1_done),
    .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .i_full(i_full),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input int src, input int pkt, input int beat);
    logic [63:0] tag;
    tag = (src == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'hBBBB_BBBB_BBBB_BBBB;
    return {tag, pkt[31:0], beat[31:0]};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input int src, input int pkt, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back({mk(src, pkt, b), (b == n - 1)});
    done_q.push_back(src);
  endtask

  task automatic set_src(input int src, input logic v, input logic [DW-1:0] d);
    if (src == 0) begin s0_valid = v; s0_data = d; end
    else begin s1_valid = v; s1_data = d; end
  endtask

  task automatic set_len(input int src, input logic [LW-1:0] l);
    if (src == 0) s0_len = l;
    else s1_len = l;
  endtask

  task automatic wait_xfer(input int src);
    int  t;
    logic acc;
    t = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = (src == 0) ? (s0_valid && s0_ready) : (s1_valid && s1_ready);
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 2000);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL xfer_timeout src%0d: got no handshake expected one within 2000 cycles", src);
    end
  endtask

  // Sends one packet; after the first beat the length input is scrambled to prove it is ignored.
  task automatic send(input int src, input int lenf, input int n, input int pkt,
                      input int gap_after, input int gap_cyc);
    set_len(src, lenf[LW-1:0]);
    for (int b = 0; b < n; b++) begin
      if (b == gap_after && gap_cyc > 0) begin
        set_src(src, 1'b0, '0);
        repeat (gap_cyc) @(posedge clk);
        #1;
      end
      set_src(src, 1'b1, mk(src, pkt, b));
      wait_xfer(src);
      if (b == 0) set_len(src, 9'd3);
    end
    set_src(src, 1'b0, '0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats and %0d dones outstanding expected 0 and 0",
               exp_q.size(), done_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    int   d;
    logic prev_last;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_last = 1'b0;
      end else begin
        if (i_full) chk("full_blocks", 128'({o_valid, s0_ready, s1_ready}), 128'(0));
        if (prev_last) chk("bubble_after_last", 128'(o_valid), 128'(0));
        if (s0_ready) chk("s0_ready_owner", 128'(o_grant), 128'(2'b01));
        if (s1_ready) chk("s1_ready_owner", 128'(o_grant), 128'(2'b10));
        if (o_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got data %0h expected no beat", o_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", o_data, e.d);
            chk("beat_last", 128'(o_last), 128'(e.last));
          end
        end
        if (s0_done || s1_done) begin
          checks++;
          if (done_q.size() == 0 || (s0_done && s1_done)) begin
            errors++;
            $display("FAIL unexpected_done: got s0_done=%0b s1_done=%0b expected none", s0_done, s1_done);
          end else begin
            d = done_q.pop_front();
            chk("done_src", 128'(s1_done), 128'(d));
          end
        end
        prev_last = o_valid && o_last;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s0_data = '0; s1_data = '0; s0_valid = 1'b0; s1_valid = 1'b0;
    s0_len = '0; s1_len = '0; i_full = 1'b0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 128'({o_valid, o_last, o_grant, o_busy, s0_ready, s1_ready, s0_done, s1_done}), 128'(0));
    chk("reset_data", o_data, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single src0 packet of 4 with grant-latency checks.
    push_pkt(0, 1, 4);
    fork
      send(0, 4, 4, 1, -1, 0);
      begin
        @(negedge clk);
        chk("grant_cycle", 128'({o_grant, s0_ready, o_valid}), 128'(0));
        @(negedge clk);
        chk("burst_start", 128'({o_grant, o_busy, o_valid}), 128'(4'b0111));
      end
    join
    drain();
    chk("grant_released", 128'(o_grant), 128'(0));

    // Backpressure: src1 of 5, full during burst cycles 2..4.
    push_pkt(1, 2, 5);
    fork
      send(1, 5, 5, 2, -1, 0);
      begin
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (!o_busy && t < 50);
        @(posedge clk);
        #1;
        i_full = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_full = 1'b0;
      end
    join
    drain();

    // Round robin: src0 3 then src1 2 then src0 2.
    push_pkt(0, 3, 3);
    push_pkt(1, 4, 2);
    push_pkt(0, 5, 2);
    fork
      begin send(0, 3, 3, 3, -1, 0); send(0, 2, 2, 5, -1, 0); end
      send(1, 2, 2, 4, -1, 0);
    join
    drain();

    // Owner bubble: src0 drops valid 2 cycles; src1 waits behind it.
    push_pkt(0, 6, 3);
    push_pkt(1, 7, 1);
    fork
      send(0, 3, 3, 6, 1, 2);
      begin
        repeat (2) @(posedge clk);
        #1;
        send(1, 1, 1, 7, -1, 0);
      end
    join
    drain();

    // Length edges.
    push_pkt(0, 8, 1);
    send(0, 0, 1, 8, -1, 0);
    drain();
    push_pkt(0, 9, 197);
    send(0, 197, 197, 9, -1, 0);
    drain();

    // Reset mid-burst after beat 2 of 4; priority pointer currently favours src1.
    exp_q.push_back({mk(0, 10, 0), 1'b0});
    exp_q.push_back({mk(0, 10, 1), 1'b0});
    s0_len = 9'd4;
    set_src(0, 1'b1, mk(0, 10, 0));
    wait_xfer(0);
    set_src(0, 1'b1, mk(0, 10, 1));
    wait_xfer(0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", 128'({o_valid, o_last, o_grant, o_busy, s0_ready, s1_ready, s0_done, s1_done}), 128'(0));
    chk("rst_mid_data", o_data, '0);
    set_src(0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_beats_done", 128'(exp_q.size()), 128'(0));
    push_pkt(0, 11, 2);
    push_pkt(1, 12, 2);
    fork
      send(0, 2, 2, 11, -1, 0);
      send(1, 2, 2, 12, -1, 0);
    join
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
